// File: rtl/edge_stream_ctrl.sv
// rtl/edge_stream_ctrl.sv - Frame sequencer between UART RX, the 3x3 edge core and UART TX.
// Tracks raster position, drives line-buffer writes, schedules windows and meters results out.
module edge_stream_ctrl #(
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     lb_wr_en,
   output logic [$clog2(IMG_W)-1:0] lb_wr_addr,
   output logic [7:0]               lb_wr_data,
   output logic                     lb_rotate,
   output logic                     win_valid,
   output logic [$clog2(IMG_H)-1:0] win_row,
   output logic [$clog2(IMG_W)-1:0] win_col,
   output logic                     win_top,
   output logic                     win_bottom,
   output logic                     win_left,
   output logic                     win_right,
   input  logic                     conv_valid,
   input  logic [7:0]               conv_data,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   input  logic                     tx_busy,
   output logic                     frame_done,
   output logic                     overflow,
   output logic                     rx_drop
);

   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int TCW = $clog2(IMG_W * IMG_H + 1);
   localparam logic [CW-1:0]  C_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  R_LAST  = RW'(IMG_H - 1);
   localparam logic [TCW-1:0] T_TOTAL = TCW'(IMG_W * IMG_H);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_t;

   state_t         state_q, state_d;
   logic [RW-1:0]  r_q, r_d;
   logic [CW-1:0]  c_q, c_d;
   logic [CW-1:0]  fc_q, fc_d;
   logic           pend_q, pend_d;
   logic [RW-1:0]  pend_row_q, pend_row_d;
   logic           lb_wr_en_q, lb_wr_en_d;
   logic [CW-1:0]  lb_wr_addr_q, lb_wr_addr_d;
   logic [7:0]     lb_wr_data_q, lb_wr_data_d;
   logic           lb_rotate_q, lb_rotate_d;
   logic           win_valid_q, win_valid_d;
   logic [RW-1:0]  win_row_q, win_row_d;
   logic [CW-1:0]  win_col_q, win_col_d;
   logic           win_top_q, win_top_d;
   logic           win_bottom_q, win_bottom_d;
   logic           win_left_q, win_left_d;
   logic           win_right_q, win_right_d;
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]     mem_q [FIFO_DEPTH];
   logic           tx_start_q, tx_start_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
   logic           frame_done_q, frame_done_d;
   logic           overflow_q, overflow_d;
   logic           rx_drop_q, rx_drop_d;

   logic           rx_accept, fifo_empty, fifo_full, push, pop;
   logic           wv;
   logic [RW-1:0]  wrow;
   logic [CW-1:0]  wcol;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rx_accept  = rx_valid && ((state_q == S_IDLE) || (state_q == S_STREAM));
   assign push       = conv_valid && !fifo_full;
   // The gap after each tx_start gives the UART one cycle to raise tx_busy.
   assign pop        = !fifo_empty && !tx_busy && !tx_start_q;

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      c_d          = c_q;
      fc_d         = fc_q;
      pend_d       = pend_q;
      pend_row_d   = pend_row_q;
      lb_wr_en_d   = 1'b0;
      lb_wr_addr_d = '0;
      lb_wr_data_d = '0;
      lb_rotate_d  = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      tx_cnt_d     = tx_cnt_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      rx_drop_d    = rx_drop_q;
      wv           = 1'b0;
      wrow         = '0;
      wcol         = '0;

      if (rx_valid && !rx_accept) begin
         rx_drop_d = 1'b1;
      end

      if (rx_accept) begin
         lb_wr_en_d   = 1'b1;
         lb_wr_addr_d = c_q;
         lb_wr_data_d = rx_data;
         lb_rotate_d  = (c_q == C_LAST);
         state_d      = S_STREAM;
         if (c_q == C_LAST) begin
            c_d = '0;
            r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            if (r_q != '0) begin
               pend_d     = 1'b1;
               pend_row_d = r_q - 1'b1;
            end
            if (r_q == R_LAST) begin
               state_d = S_FLUSH;
            end
         end else begin
            c_d = c_q + 1'b1;
         end
      end

      // Window source priority: primary from input, deferred right edge, then bottom-row flush.
      if (rx_accept && (r_q != '0) && (c_q != '0)) begin
         wv   = 1'b1;
         wrow = r_q - 1'b1;
         wcol = c_q - 1'b1;
      end else if (pend_q) begin
         wv     = 1'b1;
         wrow   = pend_row_q;
         wcol   = C_LAST;
         pend_d = 1'b0;
      end else if (state_q == S_FLUSH) begin
         wv   = 1'b1;
         wrow = R_LAST;
         wcol = fc_q;
         if (fc_q == C_LAST) begin
            fc_d    = '0;
            state_d = S_DRAIN;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end

      win_valid_d  = wv;
      win_row_d    = wrow;
      win_col_d    = wcol;
      win_top_d    = wv && (wrow == '0);
      win_bottom_d = wv && (wrow == R_LAST);
      win_left_d   = wv && (wcol == '0);
      win_right_d  = wv && (wcol == C_LAST);

      if (conv_valid) begin
         if (fifo_full) begin
            overflow_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end

      if (pop) begin
         tx_start_d = 1'b1;
         tx_data_d  = mem_q[rd_ptr_q[AW-1:0]];
         rd_ptr_d   = rd_ptr_q + 1'b1;
         tx_cnt_d   = tx_cnt_q + 1'b1;
      end

      if ((state_q == S_DRAIN) && (tx_cnt_q == T_TOTAL) && fifo_empty && !tx_busy && !tx_start_q) begin
         frame_done_d = 1'b1;
         state_d      = S_IDLE;
         tx_cnt_d     = '0;
         r_d          = '0;
         c_d          = '0;
         fc_d         = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         r_q          <= '0;
         c_q          <= '0;
         fc_q         <= '0;
         pend_q       <= 1'b0;
         pend_row_q   <= '0;
         lb_wr_en_q   <= 1'b0;
         lb_wr_addr_q <= '0;
         lb_wr_data_q <= '0;
         lb_rotate_q  <= 1'b0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         win_top_q    <= 1'b0;
         win_bottom_q <= 1'b0;
         win_left_q   <= 1'b0;
         win_right_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         tx_cnt_q     <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         rx_drop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         fc_q         <= fc_d;
         pend_q       <= pend_d;
         pend_row_q   <= pend_row_d;
         lb_wr_en_q   <= lb_wr_en_d;
         lb_wr_addr_q <= lb_wr_addr_d;
         lb_wr_data_q <= lb_wr_data_d;
         lb_rotate_q  <= lb_rotate_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         win_top_q    <= win_top_d;
         win_bottom_q <= win_bottom_d;
         win_left_q   <= win_left_d;
         win_right_q  <= win_right_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         tx_cnt_q     <= tx_cnt_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         rx_drop_q    <= rx_drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q[AW-1:0]] <= conv_data;
      end
   end

   assign lb_wr_en   = lb_wr_en_q;
   assign lb_wr_addr = lb_wr_addr_q;
   assign lb_wr_data = lb_wr_data_q;
   assign lb_rotate  = lb_rotate_q;
   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign win_top    = win_top_q;
   assign win_bottom = win_bottom_q;
   assign win_left   = win_left_q;
   assign win_right  = win_right_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign rx_drop    = rx_drop_q;

endmodule

// File: tb/tb_edge_stream_ctrl.sv
// tb/tb_edge_stream_ctrl.sv - Randomized self-checking bench for edge_stream_ctrl.
module tb_edge_stream_ctrl;
   localparam int W = 4;
   localparam int H = 3;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       conv_valid = 1'b0;
   logic [7:0] conv_data = 8'h00;
   logic       tx_busy = 1'b0;
   logic       lb_wr_en, lb_rotate, win_valid, win_top, win_bottom, win_left, win_right;
   logic [1:0] lb_wr_addr, win_row, win_col;
   logic [7:0] lb_wr_data, tx_data;
   logic       tx_start, frame_done, overflow, rx_drop;
   logic [32:0] all_outs;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [63:0] win_log[$];
   logic [63:0] lb_log[$];
   logic [7:0]  mq[$];
   logic [7:0]  tx_log[$];
   int  fd_cnt = 0, stray = 0, consec = 0, busy_left = 0, busy_dur = 1;
   bit  hold_busy = 0, man_v = 0, exp_ovf = 0, txs_prev = 0;
   logic [7:0] man_d = 8'h00;

   edge_stream_ctrl #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .lb_rotate(lb_rotate),
      .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
      .win_top(win_top), .win_bottom(win_bottom), .win_left(win_left), .win_right(win_right),
      .conv_valid(conv_valid), .conv_data(conv_data),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .frame_done(frame_done), .overflow(overflow), .rx_drop(rx_drop)
   );

   assign all_outs = {lb_wr_en, lb_wr_addr, lb_wr_data, lb_rotate, win_valid, win_row, win_col,
                      win_top, win_bottom, win_left, win_right, tx_start, tx_data,
                      frame_done, overflow, rx_drop};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pk_win(input int t, input int r, input int c);
      return {12'd0, t[31:0], r[7:0], c[7:0], r == 0, r == H - 1, c == 0, c == W - 1};
   endfunction

   function automatic logic [63:0] pk_lb(input int t, input int a, input logic [7:0] d);
      return {15'd0, t[31:0], a[7:0], d, a == W - 1};
   endfunction

   // UART/core environment plus FIFO reference: a byte queue updated once per clock edge.
   always @(negedge clk) begin
      bit full_pre, exp_pop;
      logic [7:0] b;
      full_pre = (mq.size() == D);
      exp_pop  = (mq.size() != 0) && !tx_busy && !txs_prev;
      if (rst) begin
         mq.delete();
         busy_left = 0;
         exp_ovf   = 0;
      end else begin
         check("tx_start_timing", tx_start, exp_pop);
         if (tx_start) begin
            if (txs_prev) consec++;
            if (mq.size() != 0) begin
               b = mq.pop_front();
               check("tx_data_order", tx_data, b);
            end
            tx_log.push_back(tx_data);
            busy_left = busy_dur;
         end
         if (conv_valid) begin
            if (full_pre) exp_ovf = 1;
            else mq.push_back(conv_data);
         end
         check("overflow_flag", overflow, exp_ovf);
         if (frame_done) fd_cnt++;
         if (win_valid)
            win_log.push_back({12'd0, 32'(cyc), 8'(win_row), 8'(win_col), win_top, win_bottom, win_left, win_right});
         else if (win_top | win_bottom | win_left | win_right) stray++;
         if (lb_wr_en)
            lb_log.push_back({15'd0, 32'(cyc), 8'(lb_wr_addr), lb_wr_data, lb_rotate});
         else if (lb_rotate) stray++;
      end
      txs_prev   = tx_start;
      tx_busy    = hold_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      conv_valid = man_v || win_valid;
      conv_data  = man_v ? man_d : 8'($urandom);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_px(input logic [7:0] d, output int t);
      @(negedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = d;
      t        = cyc;
      @(negedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(negedge clk); #1;
      man_v = 1'b1;
      man_d = d;
      @(negedge clk); #1;
      man_v = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst = 1'b1;
      tick(2);
      check("reset_outputs", all_outs, 0);
      rst = 1'b0;
   endtask

   task automatic run_frame(input int gmin, input int gmax, input bit late);
      logic [63:0] ew[$];
      logic [63:0] el[$];
      int t, tl, r, c;
      logic [7:0] d;
      win_log.delete(); lb_log.delete(); tx_log.delete();
      fd_cnt = 0; stray = 0; busy_dur = 1;
      t = 0;
      for (int k = 0; k < W * H; k++) begin
         d = 8'($urandom);
         r = k / W;
         c = k % W;
         if (k != 0) tick(int'($urandom_range(gmax, gmin)) - 3);
         send_px(d, t);
         el.push_back(pk_lb(t + 1, c, d));
         if (r >= 1 && c >= 1) ew.push_back(pk_win(t + 1, r - 1, c - 1));
         if (r >= 1 && c == W - 1) ew.push_back(pk_win(t + 2, r - 1, W - 1));
      end
      for (int j = 0; j < W; j++) ew.push_back(pk_win(t + 3 + j, H - 1, j));
      if (late) begin
         @(negedge clk); #1;
         send_px(8'hEE, tl);
      end
      for (int i = 0; i < 500 && fd_cnt == 0; i++) tick(1);
      tick(10);
      check("frame_done_pulses", fd_cnt, 1);
      check("win_count", win_log.size(), ew.size());
      for (int i = 0; i < ew.size() && i < win_log.size(); i++) check("win_entry", win_log[i], ew[i]);
      check("lb_count", lb_log.size(), el.size());
      for (int i = 0; i < el.size() && i < lb_log.size(); i++) check("lb_entry", lb_log[i], el[i]);
      check("tx_count", tx_log.size(), W * H);
      check("rx_drop", rx_drop, late);
      check("stray_flags", stray, 0);
      check("overflow_clear", overflow, 0);
   endtask

   initial begin
      int t;
      tick(2);
      check("reset_outputs", all_outs, 0);
      rst = 1'b0;
      tick(2);

      // TX pacing under a held-busy UART
      hold_busy = 1; tx_log.delete(); consec = 0;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      tick(20);
      check("pace_held_no_tx", tx_log.size(), 0);
      busy_dur = int'($urandom_range(5, 2));
      hold_busy = 0;
      for (int i = 0; i < 200 && tx_log.size() < 3; i++) tick(1);
      check("pace_tx_count", tx_log.size(), 3);
      if (tx_log.size() == 3) begin
         check("pace_b0", tx_log[0], 8'h11);
         check("pace_b1", tx_log[1], 8'h22);
         check("pace_b2", tx_log[2], 8'h33);
      end
      check("pace_no_back_to_back", consec, 0);
      tick(10);

      // Overflow on the fifth push into a four-entry FIFO
      hold_busy = 1; tx_log.delete();
      for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
      tick(3);
      check("ovf_set", overflow, 1);
      hold_busy = 0;
      for (int i = 0; i < 200 && tx_log.size() < 4; i++) tick(1);
      tick(20);
      check("ovf_tx_count", tx_log.size(), 4);
      for (int i = 0; i < 4 && i < tx_log.size(); i++) check("ovf_byte", tx_log[i], 8'hA0 + 8'(i));
      check("ovf_sticky", overflow, 1);
      do_reset();
      tick(2);

      run_frame(12, 12, 0);
      run_frame(5, 10, 0);
      run_frame(5, 9, 1);

      // Abandon a frame after 7 pixels, then restart from (0,0)
      fd_cnt = 0;
      for (int k = 0; k < 7; k++) begin
         send_px(8'($urandom), t);
         tick(3);
      end
      do_reset();
      tick(5);
      check("abort_no_frame_done", fd_cnt, 0);
      run_frame(5, 8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
